bg_fb_writer: RTL and testbench

BG_FB_WRITER -- requirements
Module: bg_fb_writer

---
 rtl/bg_fb_writer.sv | 127 ++++++++++++
 tb/tb_bg_fb_writer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_fb_writer.sv
// Frame-buffer loader: unpacks a stream of bytes (two 4-bit grey pixels per
// byte, high nibble first) into linear frame-buffer writes, one pixel per
// write strobe, for exactly one frame per start request.
//
// Handshake: in_data is taken on a rising pclk edge where in_valid and
// in_ready are both high. in_ready is a decode of the state register only,
// so it never depends on in_valid within the same cycle.
module bg_fb_writer #(
    parameter int FB_W = 400,
    parameter int FB_H = 300
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [21:0] wr_addr,
    output logic [3:0]  wr_data,
    output logic        busy,
    output logic        done
);
    localparam int XW = (FB_W > 1) ? $clog2(FB_W) : 1;
    localparam int YW = (FB_H > 1) ? $clog2(FB_H) : 1;
    localparam logic [21:0]   LAST  = 22'(FB_W * FB_H - 1);
    localparam logic [XW-1:0] X_MAX = XW'(FB_W - 1);

    typedef enum logic [2:0] {IDLE, WAIT_BYTE, WR_HI, WR_LO, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [3:0]    lo_nib;     // second pixel of the captured byte
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [21:0]   addr_cnt;   // address of the next pixel to be written
    logic          take_byte;
    logic          go_lo;
    logic          advance;

    // Outputs decoded from the state register; abort suppresses a pending write.
    assign in_ready = (state == WAIT_BYTE);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign wr_en    = ((state == WR_HI) || (state == WR_LO)) && !abort;

    assign take_byte = (state == WAIT_BYTE) && (state_nx == WR_HI);
    assign go_lo     = (state == WR_HI) && (state_nx == WR_LO);
    // The counter stops on the last pixel instead of wrapping to 0.
    assign advance   = take_byte || (go_lo && (addr_cnt != LAST));

    // State register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; abort wins over everything outside IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start && !abort) state_nx = WAIT_BYTE;
            end
            WAIT_BYTE: begin
                if (abort)         state_nx = IDLE;
                else if (in_valid) state_nx = WR_HI;
            end
            WR_HI: begin
                state_nx = abort ? IDLE : WR_LO;
            end
            WR_LO: begin
                if (abort)                state_nx = IDLE;
                else if (wr_addr == LAST) state_nx = DONE;
                else                      state_nx = WAIT_BYTE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // x/y/linear address counters; linear address tracks y*FB_W+x by incrementing.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
        end else if ((state == IDLE) && (state_nx == WAIT_BYTE)) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            addr_cnt <= '0;
        end else if (advance) begin
            addr_cnt <= addr_cnt + 22'd1;
            if (x_cnt == X_MAX) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + YW'(1);
            end else begin
                x_cnt <= x_cnt + XW'(1);
            end
        end
    end

    // Byte capture and write address/data registers; they hold while wr_en is low.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            lo_nib  <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (take_byte) begin
            lo_nib  <= in_data[3:0];
            wr_data <= in_data[7:4];
            wr_addr <= addr_cnt;
        end else if (go_lo) begin
            wr_data <= lo_nib;
            wr_addr <= addr_cnt;
        end
    end

endmodule

// File: tb/tb_bg_fb_writer.sv
// Bench for bg_fb_writer: a 4x2 instance for the directed sequences and a
// 40x30 instance that streams a whole frame.
module tb_bg_fb_writer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- small DUT (4x2) ----------------
    logic        start, abort, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, wr_en, busy, done;
    logic [21:0] wr_addr;
    logic [3:0]  wr_data;

    bg_fb_writer #(.FB_W(4), .FB_H(2)) dut (
        .pclk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    // ---------------- full-frame DUT (40x30) ----------------
    logic        b_start, b_valid;
    logic [7:0]  b_data;
    logic        b_ready, b_wr_en, b_busy, b_done;
    logic [21:0] b_addr;
    logic [3:0]  b_wdata;

    bg_fb_writer #(.FB_W(40), .FB_H(30)) dut_big (
        .pclk(clk), .rst_n(rst_n), .start(b_start), .abort(1'b0),
        .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .wr_en(b_wr_en), .wr_addr(b_addr), .wr_data(b_wdata),
        .busy(b_busy), .done(b_done)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int b_wcnt = 0;
    int b_done_cnt = 0;
    logic [21:0] b_last_addr = '0;
    logic [5:0]  b_last_x = '0;
    logic [4:0]  b_last_y = '0;
    logic [7:0]  b_kb;
    logic [25:0] exp_q[$];   // {addr, data} of every expected small-DUT write

    typedef struct {
        logic [7:0]  b;
        logic [21:0] a_hi;
        logic [3:0]  d_hi;
        logic [21:0] a_lo;
        logic [3:0]  d_lo;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out @%0t", name, $time);
    endtask

    // ---------------- scoreboards (sample at the active edge, pre-update) ----------------
    always @(posedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("unexpected_write", {6'b0, wr_addr, wr_data}, 32'hffff_ffff);
            else                   check("write_seq", {6'b0, wr_addr, wr_data}, {6'b0, exp_q.pop_front()});
        end
        if (done) done_cnt++;
    end

    always @(posedge clk) begin
        if (b_wr_en) begin
            b_kb = 8'(b_wcnt / 2);
            check("big_addr", {10'b0, b_addr}, b_wcnt);
            check("big_data", {28'b0, b_wdata}, {28'b0, (b_wcnt % 2 == 1) ? b_kb[3:0] : b_kb[7:4]});
            b_last_addr = b_addr;
            b_last_x    = dut_big.x_cnt;
            b_last_y    = dut_big.y_cnt;
            b_wcnt++;
        end
        if (b_done) b_done_cnt++;
    end

    // ---------------- driver tasks (all called at a negedge) ----------------
    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("ready_after_start", in_ready, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("accept");
        @(negedge clk);
    endtask

    // Sends one table byte, checks both writes, then optionally idles in WAIT_BYTE.
    task automatic apply_vec(input int i, input int gap);
        exp_q.push_back({vecs[i].a_hi, vecs[i].d_hi});
        exp_q.push_back({vecs[i].a_lo, vecs[i].d_lo});
        send_byte(vecs[i].b);
        check("hi_en",   wr_en, 1);
        check("hi_addr", wr_addr, vecs[i].a_hi);
        check("hi_data", wr_data, vecs[i].d_hi);
        check("hi_ready", in_ready, 0);
        @(negedge clk);
        check("lo_en",   wr_en, 1);
        check("lo_addr", wr_addr, vecs[i].a_lo);
        check("lo_data", wr_data, vecs[i].d_lo);
        if (gap > 0) begin
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("gap_wr_en", wr_en, 0);
                check("gap_ready", in_ready, 1);
                check("gap_addr_hold", wr_addr, vecs[i].a_lo);
            end
        end
    endtask

    task automatic finish_frame(input int exp_done);
        @(negedge clk);
        check("done_pulse", done, 1);
        check("busy_in_done", busy, 1);
        check("done_wr_en", wr_en, 0);
        @(negedge clk);
        check("done_cleared", done, 0);
        check("busy_fell", busy, 0);
        check("idle_ready", in_ready, 0);
        check("done_count", done_cnt, exp_done);
        check("exp_drained", exp_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_wr_en"},    wr_en, 0);
        check({tag, "_wr_addr"},  wr_addr, 0);
        check({tag, "_wr_data"},  wr_data, 0);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_done"},     done, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int n;
        vecs[0] = '{8'h12, 22'd0, 4'h1, 22'd1, 4'h2};
        vecs[1] = '{8'h34, 22'd2, 4'h3, 22'd3, 4'h4};
        vecs[2] = '{8'h56, 22'd4, 4'h5, 22'd5, 4'h6};
        vecs[3] = '{8'h78, 22'd6, 4'h7, 22'd7, 4'h8};

        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        b_start = 1'b0; b_valid = 1'b0; b_data = 8'h00;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full frame, in_valid held high throughout.
        start_frame();
        for (int i = 0; i < 4; i++) apply_vec(i, 0);
        in_valid = 1'b0;
        finish_frame(1);

        // Gaps of 5 cycles between bytes; start held high mid-frame is ignored.
        start_frame();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) start = 1'b1;
            if (i == 3) start = 1'b0;
            apply_vec(i, (i < 3) ? 5 : 0);
        end
        in_valid = 1'b0;
        finish_frame(2);

        // start together with abort in IDLE stays idle.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        check("start_abort_ready", in_ready, 0);
        @(negedge clk);
        check("start_abort_busy2", busy, 0);

        // Abort during WR_HI of the second byte.
        base = wr_cnt;
        start_frame();
        apply_vec(0, 0);
        send_byte(vecs[1].b);
        abort = 1'b1;
        #1;
        check("abort_wr_en", wr_en, 0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", in_ready, 0);
        check("abort_done", done, 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_stays_idle", busy, 0);
        end
        in_valid = 1'b0;
        check("abort_write_count", wr_cnt - base, 2);
        check("abort_done_count", done_cnt, 2);
        start_frame();
        for (int i = 0; i < 4; i++) apply_vec(i, 0);
        in_valid = 1'b0;
        finish_frame(3);

        // Asynchronous reset after the third byte.
        start_frame();
        for (int i = 0; i < 3; i++) apply_vec(i, 0);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        check("rst_exp_drained", exp_q.size(), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        base = wr_cnt;
        in_data = 8'hAB;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_idle_busy", busy, 0);
            check("post_rst_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        check("post_rst_no_writes", wr_cnt - base, 0);
        start_frame();
        for (int i = 0; i < 4; i++) apply_vec(i, 0);
        in_valid = 1'b0;
        finish_frame(4);

        // Whole frame on the 40x30 instance: 600 bytes, 1200 writes.
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int k = 0; k < 600; k++) begin
            n = 0;
            b_data  = 8'(k);
            b_valid = 1'b1;
            while (!b_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!b_ready) fail_now("big_accept");
            @(negedge clk);
        end
        b_valid = 1'b0;
        n = 0;
        while (b_done_cnt == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (b_done_cnt == 0) fail_now("big_done");
        repeat (3) @(negedge clk);
        check("big_write_total", b_wcnt, 1200);
        check("big_last_addr", b_last_addr, 1199);
        check("big_last_x", b_last_x, 39);
        check("big_last_y", b_last_y, 29);
        check("big_done_once", b_done_cnt, 1);
        check("big_busy_fell", b_busy, 0);
        check("big_addr_no_wrap", b_addr, 1199);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
